ahb3lite_sram_ws: RTL and testbench

//  Parametrised AHB3-Lite single-port SRAM slave; successor to the fixed 32-bit zero-wait SRAM slave.

---
 rtl/ahb3lite_pkg.sv | 31 +++
 rtl/sram_bytewise_array.sv | 25 ++
 rtl/ahb3lite_sram_ws.sv | 143 ++++++++++++++
 tb/tb_ahb3lite_sram_ws.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - shared AHB3-Lite constants, SRAM slave state type and byte-enable helper
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} sram_ws_state_t;

  // Little-endian lane mask for up to 8 byte lanes; callers keep the lanes they have.
  function automatic logic [7:0] size_to_be(input logic [2:0] haddr_lsb, input logic [2:0] hsize);
    logic [7:0] mask;
    case (hsize)
      HSIZE_BYTE:  mask = 8'h01;
      HSIZE_HWORD: mask = 8'h03;
      HSIZE_WORD:  mask = 8'h0F;
      default:     mask = 8'hFF;
    endcase
    return mask << haddr_lsb;
  endfunction

endpackage

// File: rtl/sram_bytewise_array.sv
// rtl/sram_bytewise_array.sv - MEM_DEPTH x DATA_WIDTH storage with per-byte write enables and async read
module sram_bytewise_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int AW         = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb3lite_sram_ws.sv
// rtl/ahb3lite_sram_ws.sv - AHB3-Lite SRAM slave with wait states and ERROR responses; AHB_SRAM_PRIV_WRITE_EN enables privileged-write region
module ahb3lite_sram_ws
  import ahb3lite_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 0,
  parameter int unsigned PRIV_BASE   = 'h200
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int AW        = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);

  sram_ws_state_t        state;
  logic [AW-1:0]         addr_q;
  logic [LANE_BITS-1:0]  lane_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic [2:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [7:0]            be_full;
  logic [7:0]            align_mask;
  logic                  accept;
  logic                  addr_err;
  logic                  priv_err;
  logic                  unused_ok;

  assign accept     = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign align_mask = (8'd1 << HSIZE) - 8'd1;

`ifdef AHB_SRAM_PRIV_WRITE_EN
  assign priv_err  = HWRITE && !HPROT[1] && ({1'b0, HADDR} >= (ADDR_WIDTH+1)'(PRIV_BASE));
  assign unused_ok = ^{HBURST, HPROT, be_full};
`else
  assign priv_err  = 1'b0;
  assign unused_ok = ^{HBURST, HPROT, be_full, 32'(PRIV_BASE)};
`endif

  assign addr_err = ({1'b0, HADDR} >= MEM_BYTES)
                  || (|(HADDR[7:0] & align_mask))
                  || (HSIZE > 3'(LANE_BITS))
                  || priv_err;

  assign be_full = size_to_be(3'(lane_q), size_q);

  sram_bytewise_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .AW         (AW)
  ) u_array (
    .clk   (HCLK),
    .we    (state == LAST && write_q),
    .addr  (addr_q),
    .be    (be_full[BYTES-1:0]),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  // Read data is live only during a read's LAST cycle; otherwise the last read value is held.
  assign HRDATA = (state == LAST && !write_q) ? mem_rdata : rdata_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      addr_q    <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
    end else begin
      if (state == LAST && !write_q) rdata_q <= mem_rdata;
      case (state)
        IDLE, LAST, ERR2: begin
          if (accept) begin
            addr_q  <= HADDR[LANE_BITS +: AW];
            lane_q  <= HADDR[LANE_BITS-1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
            if (addr_err) begin
              state     <= ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= HRESP_ERROR;
            end else if (WAIT_STATES == 0) begin
              state     <= LAST;
              HREADYOUT <= 1'b1;
              HRESP     <= HRESP_OKAY;
            end else begin
              state     <= WAIT;
              wait_cnt  <= 3'(WAIT_STATES - 1);
              HREADYOUT <= 1'b0;
              HRESP     <= HRESP_OKAY;
            end
          end else begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            state     <= LAST;
            HREADYOUT <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: begin
          state     <= IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// tb/tb_ahb3lite_sram_ws.sv - directed self-checking bench for ahb3lite_sram_ws (32-bit, 256 words, 2 wait states)
module tb_ahb3lite_sram_ws;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  wire         hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  int vectors = 0;
  int miscompares = 0;

  int          lows;
  logic        ro0, rs0, resp_last;
  logic [31:0] rd;

  assign hready = hreadyout;

  always #5 hclk = ~hclk;

  ahb3lite_sram_ws #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .MEM_DEPTH   (256),
    .WAIT_STATES (2),
    .PRIV_BASE   ('h200)
  ) dut (
    .HCLK      (hclk),
    .HRESETn   (hresetn),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HBURST    (hburst),
    .HPROT     (hprot),
    .HTRANS    (htrans),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HRDATA    (hrdata),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One non-pipelined transfer: address phase, bounded data phase, return to idle.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                      output logic ready0, output logic resp0, output int n_low,
                      output logic resp_end, output logic [31:0] rdat);
    hsel = 1'b1; haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    ready0 = hreadyout; resp0 = hresp;
    n_low = 0;
    while (hreadyout !== 1'b1 && n_low < 20) begin
      n_low++;
      @(posedge hclk); #1;
    end
    resp_end = hresp; rdat = hrdata;
    @(posedge hclk); #1;
  endtask

  initial begin
    hresetn = 1'b0; hsel = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd0; hprot = 4'b0011; htrans = 2'b00; hwdata = '0;

    // Reset state
    repeat (3) @(posedge hclk);
    #1;
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp",     32'(hresp),     32'd0);
    check("rst_hrdata",    hrdata,         32'h0);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // Word write then read, two wait states each
    xfer(1'b1, 32'h10, 3'd2, 32'h1234_5678, ro0, rs0, lows, resp_last, rd);
    check("wr10_waits", 32'(lows), 32'd2);
    check("wr10_resp",  32'(resp_last), 32'd0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, ro0, rs0, lows, resp_last, rd);
    check("rd10_waits", 32'(lows), 32'd2);
    check("rd10_data",  rd, 32'h1234_5678);

    // Byte write into lane 1
    xfer(1'b1, 32'h11, 3'd0, 32'h0000_AB00, ro0, rs0, lows, resp_last, rd);
    check("wr11_resp",  32'(resp_last), 32'd0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, ro0, rs0, lows, resp_last, rd);
    check("rd10_byte",  rd, 32'h1234_AB78);

    // Last valid word and word 0 as aliasing witness
    xfer(1'b1, 32'h3FC, 3'd2, 32'hCAFE_F00D, ro0, rs0, lows, resp_last, rd);
    xfer(1'b1, 32'h000, 3'd2, 32'hA5A5_0000, ro0, rs0, lows, resp_last, rd);
    xfer(1'b0, 32'h3FC, 3'd2, 32'h0, ro0, rs0, lows, resp_last, rd);
    check("rd3fc_data", rd, 32'hCAFE_F00D);
    check("rd3fc_resp", 32'(resp_last), 32'd0);

    // Out-of-range write: two-cycle ERROR
    xfer(1'b1, 32'h400, 3'd2, 32'hFFFF_FFFF, ro0, rs0, lows, resp_last, rd);
    check("oor_err1_ready", 32'(ro0), 32'd0);
    check("oor_err1_resp",  32'(rs0), 32'd1);
    check("oor_lows",       32'(lows), 32'd1);
    check("oor_err2_resp",  32'(resp_last), 32'd1);

    // Misaligned halfword write: two-cycle ERROR
    xfer(1'b1, 32'h13, 3'd1, 32'hFFFF_FFFF, ro0, rs0, lows, resp_last, rd);
    check("mis_err1_ready", 32'(ro0), 32'd0);
    check("mis_err1_resp",  32'(rs0), 32'd1);
    check("mis_err2_resp",  32'(resp_last), 32'd1);

    // Word wider than the bus: ERROR
    xfer(1'b0, 32'h18, 3'd3, 32'h0, ro0, rs0, lows, resp_last, rd);
    check("wide_err_resp",  32'(rs0), 32'd1);

    // Memory unchanged by the failed writes
    xfer(1'b0, 32'h10, 3'd2, 32'h0, ro0, rs0, lows, resp_last, rd);
    check("after_err_rd10", rd, 32'h1234_AB78);
    xfer(1'b0, 32'h00, 3'd2, 32'h0, ro0, rs0, lows, resp_last, rd);
    check("after_err_rd00", rd, 32'hA5A5_0000);

    // Pipelined write then read of the same word
    hsel = 1'b1; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge hclk); #1;
    hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
    for (int n = 0; n < 20 && hreadyout !== 1'b1; n++) begin
      @(posedge hclk); #1;
    end
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0;
    check("pipe_rd_wait", 32'(hreadyout), 32'd0);
    lows = 0;
    while (hreadyout !== 1'b1 && lows < 20) begin
      lows++;
      @(posedge hclk); #1;
    end
    check("pipe_rd_lows", 32'(lows), 32'd2);
    check("pipe_rd_data", hrdata, 32'hDEAD_BEEF);
    @(posedge hclk); #1;
    check("pipe_rd_hold", hrdata, 32'hDEAD_BEEF);

    // Reset during the wait states of a write drops the write
    xfer(1'b1, 32'h30, 3'd2, 32'h0102_0304, ro0, rs0, lows, resp_last, rd);
    hsel = 1'b1; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    check("abort_in_wait", 32'(hreadyout), 32'd0);
    #2 hresetn = 1'b0;
    #1;
    check("abort_hreadyout", 32'(hreadyout), 32'd1);
    check("abort_hrdata",    hrdata, 32'h0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;
    xfer(1'b0, 32'h30, 3'd2, 32'h0, ro0, rs0, lows, resp_last, rd);
    check("abort_rd30", rd, 32'h0102_0304);

`ifdef AHB_SRAM_PRIV_WRITE_EN
    hprot = 4'b0011;
    xfer(1'b1, 32'h200, 3'd2, 32'h5555_AAAA, ro0, rs0, lows, resp_last, rd);
    check("priv_wr_ok", 32'(resp_last), 32'd0);
    hprot = 4'b0001;
    xfer(1'b1, 32'h200, 3'd2, 32'h0BAD_0BAD, ro0, rs0, lows, resp_last, rd);
    check("unpriv_wr_err", 32'(rs0), 32'd1);
    xfer(1'b0, 32'h200, 3'd2, 32'h0, ro0, rs0, lows, resp_last, rd);
    check("unpriv_rd_ok", 32'(resp_last), 32'd0);
    check("unpriv_rd_data", rd, 32'h5555_AAAA);
    hprot = 4'b0011;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
